// File: rtl/meduram_pkg.sv
// meduram_pkg: shared FSM state, select-width rule and latency constant
// for the N-write/M-read multiport RAM.
package meduram_pkg;

    localparam int RD_LATENCY = 2;

    typedef enum logic {INIT, RUN} state_e;

    function automatic int select_width(input int nb);
        return (nb == 1) ? 1 : $clog2(nb);
    endfunction

endpackage

// File: rtl/meduram_lvt.sv
// meduram_lvt: live-value table recording which writer last wrote each address,
// with lowest-index write arbitration, registered read selects and collision pulses.
module meduram_lvt
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int NB_WRAGENT = 3,
    parameter int NB_RDAGENT = 4,
    parameter int SEL_W      = select_width(NB_WRAGENT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             init_en,
    input  logic [ADDR_WIDTH-1:0]            init_addr,
    input  logic [NB_WRAGENT-1:0]            wr_req,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rd_addr,
    output logic [NB_WRAGENT-1:0]            wr_win,
    output logic [NB_WRAGENT-1:0]            wr_collision,
    output logic [NB_RDAGENT*SEL_W-1:0]      rd_sel
);

    logic [SEL_W-1:0]              lvt_q [RAM_DEPTH];
    logic [NB_WRAGENT-1:0]         lose;
    logic [NB_WRAGENT-1:0]         coll_q;
    logic [NB_RDAGENT*SEL_W-1:0]   sel_d, sel_q;

    // A requester loses when any lower-indexed requester targets the same address.
    always_comb begin
        lose = '0;
        for (int i = 0; i < NB_WRAGENT; i++)
            for (int k = 0; k < i; k++)
                if (wr_req[k] && wr_req[i] &&
                    wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
                    lose[i] = 1'b1;
        wr_win = wr_req & ~lose;
    end

    always_comb begin
        sel_d = '0;
        for (int j = 0; j < NB_RDAGENT; j++)
            sel_d[j*SEL_W +: SEL_W] = (32'(rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]) < RAM_DEPTH)
                                    ? lvt_q[rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] : '0;
    end

    always_ff @(posedge clk) begin
        if (init_en)
            lvt_q[init_addr] <= '0;
        else
            for (int i = 0; i < NB_WRAGENT; i++)
                if (wr_win[i])
                    lvt_q[wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= SEL_W'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_q <= '0;
            sel_q  <= '0;
        end else begin
            coll_q <= lose;
            sel_q  <= sel_d;
        end
    end

    assign wr_collision = coll_q;
    assign rd_sel       = sel_q;

endmodule

// File: rtl/meduram_nwmr.sv
// meduram_nwmr: N-write/M-read multiport RAM from replicated banks plus an LVT,
// with zero-init sequencer and 2-cycle registered reads. Optional MEDURAM_BYPASS_EN.
module meduram_nwmr
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = 64,
    parameter int NB_WRAGENT = 3,
    parameter int NB_RDAGENT = 4
) (
    input  logic                             aclk,
    input  logic                             areset,
    output logic                             ready,
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    input  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
    output logic [NB_WRAGENT-1:0]            wrcollision,
    input  logic [NB_RDAGENT-1:0]            rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
    output logic [NB_RDAGENT*DATA_WIDTH-1:0] rddata,
    output logic [NB_RDAGENT-1:0]            rdvalid
);

    localparam int SEL_W = select_width(NB_WRAGENT);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      cnt_q, cnt_d;
    logic [NB_WRAGENT-1:0]      wr_req, wr_win;
    logic [NB_RDAGENT-1:0]      rd_req, rd_ok;
    logic [NB_RDAGENT-1:0]      v1_q, v2_q, oor1_q;
    logic [NB_RDAGENT*SEL_W-1:0] rd_sel;
    logic [DATA_WIDTH-1:0]      bank_q [NB_WRAGENT][NB_RDAGENT][RAM_DEPTH];
    logic [DATA_WIDTH-1:0]      rd1_d  [NB_WRAGENT][NB_RDAGENT];
    logic [DATA_WIDTH-1:0]      rd1_q  [NB_WRAGENT][NB_RDAGENT];
    logic [DATA_WIDTH-1:0]      hit_data  [NB_RDAGENT];
    logic [DATA_WIDTH-1:0]      rddata_d  [NB_RDAGENT];
    logic [DATA_WIDTH-1:0]      rddata_q  [NB_RDAGENT];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST)
                state_d = RUN;
        end
    end

    assign ready = (state_q == RUN);

    always_comb begin
        for (int i = 0; i < NB_WRAGENT; i++)
            wr_req[i] = ready && wren[i] && (32'(wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]) < RAM_DEPTH);
        for (int j = 0; j < NB_RDAGENT; j++) begin
            rd_req[j] = ready && rden[j];
            rd_ok[j]  = 32'(rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]) < RAM_DEPTH;
        end
    end

    meduram_lvt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .NB_WRAGENT (NB_WRAGENT),
        .NB_RDAGENT (NB_RDAGENT),
        .SEL_W      (SEL_W)
    ) u_lvt (
        .clk          (aclk),
        .rst          (areset),
        .init_en      (!ready),
        .init_addr    (cnt_q),
        .wr_req       (wr_req),
        .wr_addr      (wraddr),
        .rd_addr      (rdaddr),
        .wr_win       (wr_win),
        .wr_collision (wrcollision),
        .rd_sel       (rd_sel)
    );

    // Row w of banks belongs to writer w; every reader owns a private copy.
    always_ff @(posedge aclk) begin
        for (int w = 0; w < NB_WRAGENT; w++)
            for (int j = 0; j < NB_RDAGENT; j++)
                if (!ready)
                    bank_q[w][j][cnt_q] <= '0;
                else if (wr_win[w])
                    bank_q[w][j][wraddr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wrdata[w*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        for (int w = 0; w < NB_WRAGENT; w++)
            for (int j = 0; j < NB_RDAGENT; j++)
                rd1_d[w][j] = bank_q[w][j][rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
    end

`ifdef MEDURAM_BYPASS_EN
    logic [NB_RDAGENT-1:0] byp_d, byp_q;
    logic [DATA_WIDTH-1:0] bypd_d [NB_RDAGENT];
    logic [DATA_WIDTH-1:0] bypd_q [NB_RDAGENT];

    // Winners never share an address, so at most one writer matches a reader.
    always_comb begin
        for (int j = 0; j < NB_RDAGENT; j++) begin
            byp_d[j]  = 1'b0;
            bypd_d[j] = '0;
            for (int i = 0; i < NB_WRAGENT; i++)
                if (wr_win[i] && wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    byp_d[j]  = 1'b1;
                    bypd_d[j] = wrdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            byp_q <= '0;
            for (int j = 0; j < NB_RDAGENT; j++)
                bypd_q[j] <= '0;
        end else begin
            byp_q <= byp_d;
            for (int j = 0; j < NB_RDAGENT; j++)
                bypd_q[j] <= bypd_d[j];
        end
    end

    always_comb begin
        for (int j = 0; j < NB_RDAGENT; j++)
            hit_data[j] = byp_q[j] ? bypd_q[j] : rd1_q[rd_sel[j*SEL_W +: SEL_W]][j];
    end
`else
    always_comb begin
        for (int j = 0; j < NB_RDAGENT; j++)
            hit_data[j] = rd1_q[rd_sel[j*SEL_W +: SEL_W]][j];
    end
`endif

    always_comb begin
        for (int j = 0; j < NB_RDAGENT; j++)
            rddata_d[j] = v1_q[j] ? (oor1_q[j] ? '0 : hit_data[j]) : rddata_q[j];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            oor1_q  <= '0;
            for (int j = 0; j < NB_RDAGENT; j++) begin
                rddata_q[j] <= '0;
                for (int w = 0; w < NB_WRAGENT; w++)
                    rd1_q[w][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v1_q    <= rd_req;
            v2_q    <= v1_q;
            oor1_q  <= ~rd_ok;
            for (int j = 0; j < NB_RDAGENT; j++) begin
                rddata_q[j] <= rddata_d[j];
                for (int w = 0; w < NB_WRAGENT; w++)
                    rd1_q[w][j] <= rd1_d[w][j];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NB_RDAGENT; j++)
            rddata[j*DATA_WIDTH +: DATA_WIDTH] = rddata_q[j];
    end

    assign rdvalid = v2_q;

endmodule

// File: tb/tb_meduram_nwmr.sv
// tb_meduram_nwmr: directed, table-driven bench for meduram_nwmr (default parameters).
module tb_meduram_nwmr;

    localparam int AW = 9;
    localparam int DW = 64;
    localparam int NW = 3;
    localparam int NR = 4;

`ifdef MEDURAM_BYPASS_EN
    localparam logic [63:0] RDW_EXP = 64'h6;
`else
    localparam logic [63:0] RDW_EXP = 64'h5;
`endif

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic            ready;
    logic [NW-1:0]   wren;
    logic [NW*AW-1:0] wraddr;
    logic [NW*DW-1:0] wrdata;
    logic [NW-1:0]   wrcollision;
    logic [NR-1:0]   rden;
    logic [NR*AW-1:0] rdaddr;
    logic [NR*DW-1:0] rddata;
    logic [NR-1:0]   rdvalid;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    meduram_nwmr dut (
        .aclk        (aclk),
        .areset      (areset),
        .ready       (ready),
        .wren        (wren),
        .wraddr      (wraddr),
        .wrdata      (wrdata),
        .wrcollision (wrcollision),
        .rden        (rden),
        .rdaddr      (rdaddr),
        .rddata      (rddata),
        .rdvalid     (rdvalid)
    );

    typedef struct packed {
        logic [2:0]       we;
        logic [2:0][8:0]  wa;
        logic [2:0][63:0] wd;
        logic [3:0]       re;
        logic [3:0][8:0]  ra;
        logic [2:0]       coll;
        logic [3:0][63:0] rd;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mkv(
        input logic [2:0] we, input logic [8:0] a0, a1, a2,
        input logic [63:0] d0, d1, d2,
        input logic [3:0] re, input logic [8:0] r0, r1, r2, r3,
        input logic [2:0] coll, input logic [63:0] e0, e1, e2, e3);
        vec_t v;
        v.we = we; v.wa = {a2, a1, a0}; v.wd = {d2, d1, d0};
        v.re = re; v.ra = {r3, r2, r1, r0};
        v.coll = coll; v.rd = {e3, e2, e1, e0};
        return v;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        wren = '0;
        rden = '0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Counts edges after reset release; ready must rise exactly after edge 512.
    task automatic init_seq(input bit gate);
        chk("ready_c0", {63'b0, ready}, 64'd0);
        for (int k = 1; k <= 512; k++) begin
            tick();
            chk($sformatf("ready_c%0d", k), {63'b0, ready}, (k == 512) ? 64'd1 : 64'd0);
            if (gate && k < 512) begin
                chk($sformatf("init_rdvalid_c%0d", k), {60'b0, rdvalid}, 64'd0);
                chk($sformatf("init_coll_c%0d", k), {61'b0, wrcollision}, 64'd0);
            end
            if (gate && k == 505) begin
                wren = 3'b111;
                wraddr = {9'd100, 9'd100, 9'd100};
                wrdata = {64'hFFFF, 64'hEEEE, 64'hDDDD};
                rden = 4'hF;
                rdaddr = {4{9'd100}};
            end
            if (k == 506) idle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        tbl[0]  = mkv(3'b101, 10, 0, 11, 64'hAAAA, 0, 64'hBBBB, 4'b0000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        tbl[1]  = mkv(3'b010, 0, 20, 0, 0, 64'h11, 0, 4'b1001, 10, 0, 0, 11, 3'b000, 64'hAAAA, 0, 0, 64'hBBBB);
        tbl[2]  = mkv(3'b100, 0, 0, 20, 0, 0, 64'h22, 4'b0000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        tbl[3]  = mkv(3'b000, 0, 0, 0, 0, 0, 0, 4'b1111, 20, 20, 20, 20, 3'b000, 64'h22, 64'h22, 64'h22, 64'h22);
        tbl[4]  = mkv(3'b111, 7, 7, 7, 64'h1, 64'h2, 64'h3, 4'b0000, 0, 0, 0, 0, 3'b110, 0, 0, 0, 0);
        tbl[5]  = mkv(3'b000, 0, 0, 0, 0, 0, 0, 4'b1111, 7, 7, 7, 7, 3'b000, 64'h1, 64'h1, 64'h1, 64'h1);
        tbl[6]  = mkv(3'b010, 0, 30, 0, 0, 64'h5, 0, 4'b0000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        tbl[7]  = mkv(3'b001, 30, 0, 0, 64'h6, 0, 0, 4'b0001, 30, 0, 0, 0, 3'b000, RDW_EXP, 0, 0, 0);
        tbl[8]  = mkv(3'b000, 0, 0, 0, 0, 0, 0, 4'b0011, 30, 5, 0, 0, 3'b000, 64'h6, 64'h0, 0, 0);
        tbl[9]  = mkv(3'b110, 0, 40, 40, 0, 64'h44, 64'h55, 4'b0000, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0);
        tbl[10] = mkv(3'b000, 0, 0, 0, 0, 0, 0, 4'b0100, 0, 0, 40, 0, 3'b000, 0, 0, 64'h44, 0);

        idle();
        wraddr = '0; wrdata = '0; rdaddr = '0;
        repeat (3) @(posedge aclk);
        chk("reset_rdvalid", {60'b0, rdvalid}, 64'd0);
        chk("reset_coll", {61'b0, wrcollision}, 64'd0);
        chk("reset_rddata0", rddata[63:0], 64'd0);
        @(negedge aclk) areset = 1'b0;
        #1;
        init_seq(1'b1);

        rden = 4'hF;
        rdaddr = {4{9'd5}};
        tick();
        idle();
        chk("addr5_valid_c1", {60'b0, rdvalid}, 64'd0);
        tick();
        chk("addr5_valid_c2", {60'b0, rdvalid}, 64'hF);
        for (int j = 0; j < NR; j++)
            chk($sformatf("addr5_data%0d", j), rddata[j*DW +: DW], 64'd0);
        tick();
        chk("addr5_valid_c3", {60'b0, rdvalid}, 64'd0);

        rden = 4'hF;
        rdaddr = {4{9'd100}};
        tick();
        idle();
        tick();
        chk("gated_valid", {60'b0, rdvalid}, 64'hF);
        for (int j = 0; j < NR; j++)
            chk($sformatf("gated_data%0d", j), rddata[j*DW +: DW], 64'd0);

        @(negedge aclk) areset = 1'b1;
        #1;
        chk("rst_async_ready", {63'b0, ready}, 64'd0);
        tick();
        @(negedge aclk) areset = 1'b0;
        repeat (200) tick();
        chk("mid_init_ready", {63'b0, ready}, 64'd0);
        @(negedge aclk) areset = 1'b1;
        #1;
        chk("mid_init_rst_ready", {63'b0, ready}, 64'd0);
        tick();
        @(negedge aclk) areset = 1'b0;
        #1;
        init_seq(1'b0);

        for (int r = 0; r < 11; r++) begin
            v = tbl[r];
            wren = v.we; wraddr = v.wa; wrdata = v.wd;
            rden = v.re; rdaddr = v.ra;
            tick();
            chk($sformatf("row%0d_coll", r), {61'b0, wrcollision}, {61'b0, v.coll});
            chk($sformatf("row%0d_valid_c1", r), {60'b0, rdvalid}, 64'd0);
            idle();
            tick();
            chk($sformatf("row%0d_coll_clear", r), {61'b0, wrcollision}, 64'd0);
            chk($sformatf("row%0d_valid_c2", r), {60'b0, rdvalid}, {60'b0, v.re});
            for (int j = 0; j < NR; j++)
                if (v.re[j])
                    chk($sformatf("row%0d_rd%0d", r, j), rddata[j*DW +: DW], v.rd[j]);
        end

        tick();
        chk("hold_valid", {60'b0, rdvalid}, 64'd0);
        chk("hold_rd2", rddata[2*DW +: DW], 64'h44);
        chk("hold_rd0", rddata[0 +: DW], 64'h6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
